pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage ARM pipeline (IF/ID/EXE/MEM/WB).
//  Generates the PC/IF-ID freeze, the IF-ID + ID-EXE flush and a global stall for the pipe registers.
//  Sources: ID-stage operands, EXE/MEM destinations, EXE branch resolution, data-memory handshake.
//  Also holds the pipe after reset, times out hung memory accesses and keeps stall/flush counters.
// PARAMETERS
//  FORWARDING   0   1: only load-use hazards freeze; 0: any RAW vs EXE/MEM freezes
//  BOOT_CYCLES  4   cycles freeze+flush held after reset release (>=1)
//  MEM_TIMEOUT  64  max MEM_WAIT cycles before abort (>=2)
//  CNT_W        16  width of performance counters
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-low reset
//  id_valid      in   1      ID stage holds a real instruction
//  id_src1       in   4      ID source register Rn
//  id_src2       in   4      ID source register Rm/Rd(store)
//  id_two_src    in   1      id_src2 is actually read
//  exe_dest      in   4      EXE-stage destination reg
//  exe_wb_en     in   1      EXE instr writes back
//  exe_mem_read  in   1      EXE instr is a load
//  mem_dest      in   4      MEM-stage destination reg
//  mem_wb_en     in   1      MEM instr writes back
//  branch_taken  in   1      EXE resolved a taken branch this cycle
//  mem_req       in   1      MEM stage issues a data-memory access
//  mem_ready     in   1      data memory completes access this cycle
//  freeze        out  1      hold PC and IF/ID register
//  flush         out  1      clear IF/ID and ID/EXE to NOP
//  stall         out  1      hold PC and all pipe registers
//  mem_err       out  1      sticky: a memory access timed out
//  stall_cnt     out  CNT_W  cycles with stall or freeze asserted (saturating)
//  flush_cnt     out  CNT_W  cycles with flush asserted (saturating)
// BEHAVIOUR
//  Reset (rst=0, async): state=BOOT, boot counter=0, wait counter=0.
//   Outputs: freeze=1, flush=1, stall=0, mem_err=0, both counters=0.
//  FSM states:
//   BOOT     freeze=1, flush=1; count BOOT_CYCLES edges, then ->RUN.
//   RUN      normal operation; mem_req & !mem_ready -> MEM_WAIT.
//   MEM_WAIT stall=1; mem_ready -> RUN.
//            Wait counter reaching MEM_TIMEOUT-1 without ready -> set mem_err, ->RUN.
//  Hazard (combinational, RUN only), qualified by id_valid:
//   FORWARDING=0: hz = (exe_wb_en & exe_dest==id_src1) | (mem_wb_en & mem_dest==id_src1),
//                 plus the same two terms on id_src2 gated by id_two_src.
//   FORWARDING=1: hz = exe_mem_read & (exe_dest==id_src1 | (id_two_src & exe_dest==id_src2)).
//  Output priority in RUN:
//   stall = mem_req & !mem_ready (same cycle, no wait state).
//   Else flush = branch_taken.
//   Else freeze = hz.
//   Only one of stall/flush/freeze is high in RUN.
//  branch_taken while stall=1 is ignored; EXE is frozen, so it re-presents after the stall.
//  Branch + hazard same cycle: flush wins, freeze=0 (the hazarding instr is squashed).
//  Timeout exit: stall drops in the cycle after the abort edge.
//   mem_err clears only on reset.
//  Wait counter clears on every entry to MEM_WAIT.
//  Counters: +1 per cycle on (stall|freeze) / flush; hold at all-ones; include BOOT cycles.
//  Latency: hazard/branch/stall outputs combinational from inputs (0 cycles); state changes on clk.
//  Reset asserted mid-MEM_WAIT: immediate return to BOOT; no mem_err set.
// TESTING
//  Release rst, idle inputs -> freeze=flush=1 for exactly 4 cycles, then 0; flush_cnt=4.
//  FORWARDING=0: id_src1=3, exe_dest=3, exe_wb_en=1 -> freeze=1; exe_wb_en=0 -> freeze=0.
//  FORWARDING=1: same stimulus with exe_mem_read=0 -> freeze=0; exe_mem_read=1 -> freeze=1.
//  branch_taken=1 together with a hazard -> flush=1, freeze=0, stall_cnt unchanged.
//  mem_req=1, mem_ready low 5 cycles then high -> stall=1 for 6 cycles, state back to RUN.
//  mem_ready never rises -> stall high for 64 cycles, mem_err=1; rst pulse clears mem_err.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: boot hold, RAW/load-use freeze,
// branch flush, data-memory wait with timeout, and saturating stall/flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | post-reset hold, freeze+flush asserted for BOOT_CYCLES edges
// RUN      | normal issue; hazard/branch/memory outputs decoded from inputs
// MEM_WAIT | data-memory access outstanding, whole pipe stalled

module pipe_hazard_ctrl #(
  parameter bit FORWARDING  = 1'b0,
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze,
  output logic             flush,
  output logic             stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [BOOT_W-1:0]   boot_cnt, boot_cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [WAIT_W-1:0]   wait_inc;
  logic                err_set;
  logic                mem_busy;
  logic                hazard;
  logic                src1_exe, src2_exe, src1_mem, src2_mem;

  assign mem_busy = mem_req & ~mem_ready;
  assign wait_inc = wait_cnt + 1'b1;

  assign src1_exe = (exe_dest == id_src1);
  assign src2_exe = id_two_src & (exe_dest == id_src2);
  assign src1_mem = (mem_dest == id_src1);
  assign src2_mem = id_two_src & (mem_dest == id_src2);

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    hazard = 1'b0;
    if (FORWARDING) begin
      hazard = exe_mem_read & (src1_exe | src2_exe);
    end else begin
      hazard = (exe_wb_en & (src1_exe | src2_exe)) |
               (mem_wb_en & (src1_mem | src2_mem));
    end
    hazard = hazard & id_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_BOOT;
      boot_cnt <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) begin
        mem_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    case (state)
      ST_BOOT: begin
        if (boot_cnt == BOOT_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          boot_cnt_nxt = boot_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (mem_busy) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      ST_MEM_WAIT: begin
        // A ready arriving on the last allowed cycle still completes normally.
        if (mem_ready) begin
          state_nxt = ST_RUN;
        end else if (wait_inc == WAIT_LAST) begin
          state_nxt = ST_RUN;
          err_set   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_inc;
        end
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    freeze = 1'b0;
    flush  = 1'b0;
    stall  = 1'b0;
    case (state)
      ST_BOOT: begin
        freeze = 1'b1;
        flush  = 1'b1;
      end
      ST_RUN: begin
        if (mem_busy) begin
          stall = 1'b1;
        end else if (branch_taken) begin
          flush = 1'b1;
        end else begin
          freeze = hazard;
        end
      end
      ST_MEM_WAIT: begin
        stall = 1'b1;
      end
      default: begin
        freeze = 1'b1;
        flush  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((stall | freeze) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
